// File: rtl/accum_ctrl.sv
// Key-driven accumulator: synchronizes and debounces two active-low keys, then
// adds the synchronized switch value once per accumulate press into a running sum.
module accum_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             Accumulate_n,
  input  logic             Clear_n,
  output logic [WIDTH-1:0] Sum,
  output logic             Overflow,
  output logic             Busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ACC = 0;
  localparam int CLR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sw_s1;
  logic [WIDTH-1:0] r_sw_s2;
  logic [1:0]       w_key_raw;
  logic [1:0]       r_key_s1;
  logic [1:0]       r_key_s2;
  logic [1:0]       r_key_deb;
  logic [1:0]       r_key_prev;
  logic [CW-1:0]    r_cnt [2];
  logic [1:0]       w_press;

  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic [WIDTH:0]   w_add;
  logic             w_load_op;
  logic             w_do_add;
  logic             w_do_clear;

  assign w_key_raw = {Clear_n, Accumulate_n};

  // SW is only synchronized; it must be stable around the press anyway.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sw_s1 <= '1;
      r_sw_s2 <= '1;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Per key: 2-flop sync, then a level only changes after a full run of
  // disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_key_s1   <= '1;
      r_key_s2   <= '1;
      r_key_deb  <= '1;
      r_key_prev <= '1;
      for (int k = 0; k < 2; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_key_s1   <= w_key_raw;
      r_key_s2   <= r_key_s1;
      r_key_prev <= r_key_deb;
      for (int k = 0; k < 2; k++) begin
        if (r_key_s2[k] == r_key_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_key_deb[k] <= r_key_s2[k];
          r_cnt[k]     <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  // One-cycle pulse on a debounced 1->0 transition only.
  assign w_press = r_key_prev & ~r_key_deb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Clear outranks accumulate in IDLE; ADD always completes.
  always_comb begin
    w_next     = r_state;
    w_load_op  = 1'b0;
    w_do_add   = 1'b0;
    w_do_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press[CLR]) begin
          w_do_clear = 1'b1;
        end else if (w_press[ACC]) begin
          w_load_op = 1'b1;
          w_next    = ADD;
        end
      end
      ADD: begin
        w_do_add = 1'b1;
        w_next   = HOLD;
      end
      HOLD: begin
        if (w_press[CLR]) begin
          w_do_clear = 1'b1;
        end
        if (r_key_deb[ACC]) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_add = {1'b0, r_sum} + {1'b0, r_operand};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_operand <= '0;
      r_sum     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_load_op) begin
        r_operand <= r_sw_s2;
      end
      if (w_do_clear) begin
        r_sum <= '0;
        r_ovf <= 1'b0;
      end else if (w_do_add) begin
        r_sum <= w_add[WIDTH-1:0];
        r_ovf <= r_ovf | w_add[WIDTH];
      end
    end
  end

  assign Sum         = r_sum;
  assign Overflow    = r_ovf;
  assign Busy        = (r_state == ADD) || (r_state == HOLD);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl: directed timing checks plus randomized key sequences,
// with every Sum/Overflow update compared against an arithmetic model via a queue.
module tb_accum_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] SW;
  logic         Accumulate_n;
  logic         Clear_n;
  logic [W-1:0] Sum;
  logic         Overflow;
  logic         Busy;
  logic [1:0]   dbg_state;

  accum_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SW           (SW),
    .Accumulate_n (Accumulate_n),
    .Clear_n      (Clear_n),
    .Sum          (Sum),
    .Overflow     (Overflow),
    .Busy         (Busy),
    .o_dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] m_sum = '0;
  logic         m_ovf = 1'b0;
  bit           mon_en = 1'b0;
  logic [W:0]   prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: running sum as plain integer arithmetic
  task automatic model_add(input logic [W-1:0] v);
    int s;
    s = int'(m_sum) + int'(v);
    if (s >= (1 << W)) m_ovf = 1'b1;
    m_sum = W'(s % (1 << W));
    exp_q.push_back({m_ovf, m_sum});
  endtask

  task automatic model_clear();
    if (m_sum != 0 || m_ovf) exp_q.push_back('0);
    m_sum = '0;
    m_ovf = 1'b0;
  endtask

  // scoreboard monitor: every visible output change must match the next expectation
  always @(negedge Clk) begin
    if (mon_en && ({Overflow, Sum} !== prev_out)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_update: got %0h expected no change from %0h", {Overflow, Sum}, prev_out);
      end else begin
        check("sum_update", {Overflow, Sum}, exp_q.pop_front());
      end
    end
    prev_out <= {Overflow, Sum};
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic press(input logic [W-1:0] v, input int hold);
    SW = v;
    step(3);
    model_add(v);
    Accumulate_n = 1'b0;
    step(hold);
    Accumulate_n = 1'b1;
    step(12);
  endtask

  task automatic clear_press(input int hold);
    Clear_n = 1'b0;
    model_clear();
    step(hold);
    Clear_n = 1'b1;
    step(10);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge Clk);
    check({tag, "_sum"}, Sum, 0);
    check({tag, "_ovf"}, Overflow, 0);
    check({tag, "_busy"}, Busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Accumulate_n = 1'b1;
    Clear_n = 1'b1;
    SW = 8'hFF;

    // reset
    @(posedge Clk);
    check_idle_outputs("reset_c1");
    @(posedge Clk);
    check_idle_outputs("reset_c2");
    check("reset_state", dbg_state, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    step(3);
    check_idle_outputs("after_reset");
    mon_en = 1'b1;

    // single add with exact latency and Busy timing
    SW = 8'h05;
    step(3);
    model_add(8'h05);
    Accumulate_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k == 6) check("busy_before_add", Busy, 0);
      if (k == 7) begin
        check("busy_add_entry", Busy, 1);
        check("sum_before_edge8", Sum, 0);
      end
      if (k == 8) check("sum_at_edge8", Sum, 8'h05);
    end
    step(12);
    Accumulate_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (k == 6) check("busy_until_release", Busy, 1);
      if (k == 7) check("busy_falls", Busy, 0);
    end
    step(5);

    // bounce rejection
    SW = 8'h03;
    step(3);
    model_add(8'h03);
    repeat (5) begin
      Accumulate_n = 1'b0;
      step(2);
      Accumulate_n = 1'b1;
      step(2);
    end
    Accumulate_n = 1'b0;
    step(10);
    Accumulate_n = 1'b1;
    step(12);
    @(negedge Clk);
    check("bounce_sum", Sum, 8'h08);

    // overflow wrap and sticky flag
    clear_press(10);
    press(8'hF0, 12);
    press(8'h20, 12);
    @(negedge Clk);
    check("wrap_sum", Sum, 8'h10);
    check("wrap_ovf", Overflow, 1);
    press(8'h01, 12);
    @(negedge Clk);
    check("sticky_sum", Sum, 8'h11);
    check("sticky_ovf", Overflow, 1);

    // simultaneous clear and accumulate: clear wins, no add
    Accumulate_n = 1'b0;
    Clear_n = 1'b0;
    model_clear();
    step(10);
    Accumulate_n = 1'b1;
    Clear_n = 1'b1;
    step(12);
    check_idle_outputs("simul");

    // clear during HOLD
    SW = 8'h22;
    step(3);
    model_add(8'h22);
    Accumulate_n = 1'b0;
    step(12);
    @(negedge Clk);
    check("hold_busy", Busy, 1);
    check("hold_sum", Sum, 8'h22);
    Clear_n = 1'b0;
    model_clear();
    step(10);
    @(negedge Clk);
    check("hold_clear_sum", Sum, 0);
    check("hold_clear_busy", Busy, 1);
    Clear_n = 1'b1;
    step(10);
    @(negedge Clk);
    check("hold_busy_after_clear", Busy, 1);
    Accumulate_n = 1'b1;
    step(12);
    @(negedge Clk);
    check("hold_busy_released", Busy, 0);

    // reset during HOLD
    SW = 8'h07;
    step(3);
    model_add(8'h07);
    Accumulate_n = 1'b0;
    step(12);
    Reset = 1'b1;
    Accumulate_n = 1'b1;
    model_clear();
    @(posedge Clk);
    check_idle_outputs("reset_hold");
    check("reset_hold_state", dbg_state, 0);
    step(1);
    Reset = 1'b0;
    step(10);
    check_idle_outputs("after_reset_hold");

    // reset during partial debounce
    Accumulate_n = 1'b0;
    step(3);
    Reset = 1'b1;
    Accumulate_n = 1'b1;
    step(1);
    Reset = 1'b0;
    step(10);
    check_idle_outputs("reset_partial");
    press(8'h09, 12);
    @(negedge Clk);
    check("post_reset_add", Sum, 8'h09);

    // randomized key sequences
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0, 1: press(W'($urandom_range(1, 255)), $urandom_range(9, 20));
        2: clear_press($urandom_range(8, 15));
        default: begin
          Clear_n = 1'b0;
          step($urandom_range(1, 3));
          Clear_n = 1'b1;
          Accumulate_n = 1'b0;
          step($urandom_range(1, 3));
          Accumulate_n = 1'b1;
          step(8);
        end
      endcase
    end

    // final report
    step(20);
    @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_sum", Sum, m_sum);
    check("final_ovf", Overflow, m_ovf);
    check("final_busy", Busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
